// File: rtl/accum_core.sv
// accum_core: 8-bit accumulator CPU, two clocks per instruction (FETCH then EXEC).
// input_ins only feeds next-state logic, so every output is a register.
module accum_core (
  input  logic       clk,
  input  logic       CLB,
  input  logic [7:0] input_ins,
  output logic [7:0] pc,
  output logic [7:0] accum_value
);
  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDH = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_SHL = 4'h8, OP_SHR = 4'h9, OP_NOT = 4'hA, OP_JMP = 4'hB,
    OP_JZ  = 4'hC, OP_JNZ = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF
  } op_t;

  state_t     state, state_nxt;
  op_t        op;
  logic [3:0] imm;
  logic [7:0] acc, acc_nxt, pc_nxt;
  logic       c, c_nxt;
  logic [7:0] imm_z, rel, pc_inc, pc_tgt;
  logic [8:0] sum, diff;

  assign op     = op_t'(input_ins[7:4]);
  assign imm    = input_ins[3:0];
  assign imm_z  = {4'h0, imm};
  assign rel    = {{4{imm[3]}}, imm};
  assign pc_inc = pc + 8'd1;
  assign pc_tgt = pc + rel;
  assign sum    = {1'b0, acc} + {1'b0, imm_z};
  // bit 8 of the 9-bit difference is the borrow, i.e. acc < imm
  assign diff   = {1'b0, acc} - {1'b0, imm_z};

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state <= FETCH;
      pc    <= 8'h00;
      acc   <= 8'h00;
      c     <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      acc   <= acc_nxt;
      c     <= c_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    pc_nxt    = pc;
    c_nxt     = c;
    case (state)
      FETCH: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_LDI: acc_nxt = imm_z;
          OP_LDH: acc_nxt = {imm, acc[3:0]};
          OP_ADD: {c_nxt, acc_nxt} = sum;
          OP_SUB: {c_nxt, acc_nxt} = diff;
          OP_AND: acc_nxt = acc & imm_z;
          OP_OR:  acc_nxt = acc | imm_z;
          OP_XOR: acc_nxt = acc ^ imm_z;
          OP_SHL: acc_nxt = acc << imm[2:0];
          OP_SHR: acc_nxt = acc >> imm[2:0];
          OP_NOT: acc_nxt = ~acc;
          OP_JMP: pc_nxt = pc_tgt;
          OP_JZ:  if (acc == 8'h00) pc_nxt = pc_tgt;
          OP_JNZ: if (acc != 8'h00) pc_nxt = pc_tgt;
          OP_JC:  if (c) pc_nxt = pc_tgt;
          OP_HLT: pc_nxt = pc;
        endcase
      end
    endcase
  end

  assign accum_value = acc;
endmodule

// File: tb/tb_accum_core.sv
// Bench for accum_core: vector tables, hand sequences for reset/HALT, and random
// programs checked against an arithmetic model of the instruction set.
module tb_accum_core;
  logic       clk;
  logic       CLB;
  logic [7:0] input_ins;
  logic [7:0] pc;
  logic [7:0] accum_value;

  logic [7:0] imem [256];
  logic [7:0] addr_q;

  int errors = 0;
  int checks = 0;
  int m_acc, m_pc, m_c;

  accum_core dut (
    .clk        (clk),
    .CLB        (CLB),
    .input_ins  (input_ins),
    .pc         (pc),
    .accum_value(accum_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory with one registered cycle of address latency
  always @(posedge clk) addr_q <= pc;
  assign input_ins = imem[addr_q];

  typedef struct {
    int         grp;
    logic [7:0] addr;
    logic [7:0] ins;
    logic [7:0] acc;
    logic [7:0] pc;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(int g, logic [7:0] a, logic [7:0] i, logic [7:0] ea, logic [7:0] ep);
    vec_t v;
    v.grp = g; v.addr = a; v.ins = i; v.acc = ea; v.pc = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {acc,pc}=%h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    CLB = 1'b0;
    #10;
    CLB = 1'b1;
    m_acc = 0; m_pc = 0; m_c = 0;
  endtask

  // one instruction: outputs must hold across the FETCH edge, then take the new value
  task automatic exec_step(input string nm, input logic [15:0] prev, input logic [15:0] exp);
    @(posedge clk); #1;
    chk({nm, "_fetch_hold"}, {accum_value, pc}, prev);
    @(posedge clk); #1;
    chk(nm, {accum_value, pc}, exp);
  endtask

  // instruction-set model written straight from the opcode table
  task automatic model_step(input logic [7:0] ins);
    int op, imm, rel, npc, s;
    op  = ins >> 4;
    imm = ins & 15;
    rel = (imm >= 8) ? imm - 16 : imm;
    npc = (m_pc + 1) % 256;
    case (op)
      1:  m_acc = imm;
      2:  m_acc = (imm * 16) + (m_acc % 16);
      3:  begin s = m_acc + imm; m_c = (s > 255); m_acc = s % 256; end
      4:  begin m_c = (m_acc < imm); m_acc = (m_acc - imm + 256) % 256; end
      5:  m_acc = m_acc & imm;
      6:  m_acc = m_acc | imm;
      7:  m_acc = m_acc ^ imm;
      8:  m_acc = (m_acc * (1 << (imm % 8))) % 256;
      9:  m_acc = m_acc / (1 << (imm % 8));
      10: m_acc = 255 - m_acc;
      11: npc = (m_pc + rel + 256) % 256;
      12: if (m_acc == 0) npc = (m_pc + rel + 256) % 256;
      13: if (m_acc != 0) npc = (m_pc + rel + 256) % 256;
      14: if (m_c != 0) npc = (m_pc + rel + 256) % 256;
      15: npc = m_pc;
      default: ;
    endcase
    m_pc = npc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev;
    logic [7:0]  ins;
    CLB = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;

    // reset held with clock running, then first update two edges after release
    #10;
    #1 chk("reset_hold", {accum_value, pc}, 16'h0000);
    @(negedge clk); CLB = 1'b1;
    @(posedge clk); #1 chk("post_reset_edge1", {accum_value, pc}, 16'h0000);
    @(posedge clk); #1 chk("post_reset_edge2", {accum_value, pc}, 16'h0001);

    // {grp, addr, ins, expected acc, expected pc} after each executed instruction
    vecs.push_back(mk(0, 8'h00, 8'h15, 8'h05, 8'h01));
    vecs.push_back(mk(0, 8'h01, 8'h33, 8'h08, 8'h02));
    vecs.push_back(mk(0, 8'h02, 8'h49, 8'hFF, 8'h03));
    vecs.push_back(mk(0, 8'h03, 8'hE2, 8'hFF, 8'h05));
    vecs.push_back(mk(1, 8'h00, 8'h1F, 8'h0F, 8'h01));
    vecs.push_back(mk(1, 8'h01, 8'h2F, 8'hFF, 8'h02));
    vecs.push_back(mk(1, 8'h02, 8'h31, 8'h00, 8'h03));
    vecs.push_back(mk(1, 8'h03, 8'hEE, 8'h00, 8'h01));
    vecs.push_back(mk(1, 8'h01, 8'h2F, 8'hF0, 8'h02));
    vecs.push_back(mk(2, 8'h00, 8'h10, 8'h00, 8'h01));
    vecs.push_back(mk(2, 8'h01, 8'hC3, 8'h00, 8'h04));
    vecs.push_back(mk(2, 8'h04, 8'hD3, 8'h00, 8'h05));
    vecs.push_back(mk(3, 8'h00, 8'h00, 8'h00, 8'h01));
    vecs.push_back(mk(3, 8'h01, 8'h00, 8'h00, 8'h02));
    vecs.push_back(mk(3, 8'h02, 8'hB8, 8'h00, 8'hFA));
    vecs.push_back(mk(3, 8'hFA, 8'hB0, 8'h00, 8'hFA));
    vecs.push_back(mk(3, 8'hFA, 8'hB0, 8'h00, 8'hFA));
    vecs.push_back(mk(4, 8'h00, 8'hBF, 8'h00, 8'hFF));
    vecs.push_back(mk(4, 8'hFF, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(4, 8'h00, 8'hBF, 8'h00, 8'hFF));
    vecs.push_back(mk(5, 8'h00, 8'h11, 8'h01, 8'h01));
    vecs.push_back(mk(5, 8'h01, 8'h28, 8'h81, 8'h02));
    vecs.push_back(mk(5, 8'h02, 8'h81, 8'h02, 8'h03));
    vecs.push_back(mk(5, 8'h03, 8'h91, 8'h01, 8'h04));
    vecs.push_back(mk(5, 8'h04, 8'hA0, 8'hFE, 8'h05));
    vecs.push_back(mk(5, 8'h05, 8'h53, 8'h02, 8'h06));
    vecs.push_back(mk(5, 8'h06, 8'h80, 8'h02, 8'h07));
    vecs.push_back(mk(5, 8'h07, 8'h65, 8'h07, 8'h08));
    vecs.push_back(mk(5, 8'h08, 8'h7F, 8'h08, 8'h09));
    vecs.push_back(mk(6, 8'h00, 8'h1F, 8'h0F, 8'h01));
    vecs.push_back(mk(6, 8'h01, 8'h31, 8'h10, 8'h02));
    vecs.push_back(mk(6, 8'h02, 8'h4F, 8'h01, 8'h03));
    vecs.push_back(mk(6, 8'h03, 8'hE2, 8'h01, 8'h04));
    vecs.push_back(mk(6, 8'h04, 8'h42, 8'hFF, 8'h05));
    vecs.push_back(mk(6, 8'h05, 8'h7F, 8'hF0, 8'h06));
    vecs.push_back(mk(6, 8'h06, 8'hE3, 8'hF0, 8'h09));
    vecs.push_back(mk(7, 8'h00, 8'h11, 8'h01, 8'h01));
    vecs.push_back(mk(7, 8'h01, 8'hDF, 8'h01, 8'h00));
    vecs.push_back(mk(7, 8'h00, 8'h11, 8'h01, 8'h01));

    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < 256; i++) imem[i] = 8'h00;
      foreach (vecs[k]) if (vecs[k].grp == g) imem[vecs[k].addr] = vecs[k].ins;
      do_reset();
      prev = 16'h0000;
      foreach (vecs[k]) begin
        if (vecs[k].grp == g) begin
          exec_step($sformatf("vec%0d_g%0d_ins%h", k, g, vecs[k].ins), prev, {vecs[k].acc, vecs[k].pc});
          prev = {vecs[k].acc, vecs[k].pc};
        end
      end
    end

    // reset asserted during EXEC: the pending LDI must not land
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[0] = 8'h15;
    do_reset();
    @(posedge clk); #2;
    CLB = 1'b0;
    #1 chk("mid_exec_reset_async", {accum_value, pc}, 16'h0000);
    @(posedge clk); #1 chk("mid_exec_reset_edge", {accum_value, pc}, 16'h0000);
    @(negedge clk); CLB = 1'b1;
    @(posedge clk); @(posedge clk); #1 chk("mid_exec_rerun", {accum_value, pc}, 16'h0501);

    // HALT at pc=7 holds for 20 cycles, then an async reset clears it
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[0] = 8'h19;
    imem[7] = 8'hF0;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      prev = {m_acc[7:0], m_pc[7:0]};
      model_step(imem[m_pc]);
      exec_step($sformatf("halt_seq%0d", s), prev, {m_acc[7:0], m_pc[7:0]});
    end
    for (int s = 0; s < 20; s++) begin
      @(posedge clk); #1;
      if (s % 5 == 0 || s == 19) chk($sformatf("halt_hold%0d", s), {accum_value, pc}, 16'h0907);
    end
    @(negedge clk); CLB = 1'b0;
    #1 chk("halt_reset", {accum_value, pc}, 16'h0000);
    #9 CLB = 1'b1;

    // random programs against the model; HALT kept rare so runs make progress
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) begin
        ins = 8'($urandom);
        if (ins[7:4] == 4'hF && $urandom_range(0, 9) != 0) ins[7:4] = 4'($urandom_range(0, 14));
        imem[i] = ins;
      end
      do_reset();
      for (int s = 0; s < 120; s++) begin
        prev = {m_acc[7:0], m_pc[7:0]};
        ins  = imem[m_pc];
        model_step(ins);
        exec_step($sformatf("rand%0d_step%0d_ins%h", r, s, ins), prev, {m_acc[7:0], m_pc[7:0]});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
